// File: rtl/eth_egress_vlan_tagger.sv
// Per-port egress VLAN stage: forwards native frames untagged, inserts an
// 802.1Q tag after the source MAC on trunk ports, drops disallowed VLANs.
module eth_egress_vlan_tagger #(
    parameter logic [15:0] TPID      = 16'h8100,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [31:0]          s_tdata,
    input  logic [3:0]           s_tkeep,
    input  logic                 s_tlast,
    input  logic                 s_tuser,
    input  logic [11:0]          s_vlan,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [31:0]          m_tdata,
    output logic [3:0]           m_tkeep,
    output logic                 m_tlast,
    output logic                 m_tuser,
    input  logic [11:0]          port_vlan,
    input  logic                 port_trunk,
    output logic [CNT_WIDTH-1:0] cnt_tagged,
    output logic [CNT_WIDTH-1:0] cnt_dropped,
    output logic [CNT_WIDTH-1:0] cnt_runt
);
    // state | meaning
    // FIRST | waiting for first beat of a frame; VLAN decision taken here
    // HDR   | forwarding beats 1 and 2 (MAC addresses)
    // TAG   | inserting the 802.1Q tag word, upstream stalled
    // BODY  | forwarding remaining beats until tlast
    // DROP  | discarding beats of a filtered frame until tlast
    typedef enum logic [2:0] {
        ST_FIRST,
        ST_HDR,
        ST_TAG,
        ST_BODY,
        ST_DROP
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t      state, state_nxt;
    logic        tag_q, tag_nxt;
    logic        hdr2_q, hdr2_nxt;
    logic [11:0] vlan_q, vlan_nxt;

    logic        out_free;
    logic        accept;
    logic        load;
    logic [31:0] ld_data;
    logic [3:0]  ld_keep;
    logic        ld_last;
    logic        ld_user;
    logic        inc_tagged;
    logic        inc_dropped;
    logic        inc_runt;

    always_comb begin
        out_free    = !m_tvalid || m_tready;
        s_tready    = 1'b0;
        state_nxt   = state;
        tag_nxt     = tag_q;
        hdr2_nxt    = hdr2_q;
        vlan_nxt    = vlan_q;
        load        = 1'b0;
        ld_data     = s_tdata;
        ld_keep     = s_tkeep;
        ld_last     = s_tlast;
        ld_user     = s_tuser;
        inc_tagged  = 1'b0;
        inc_dropped = 1'b0;
        inc_runt    = 1'b0;

        if (areset_n) begin
            case (state)
                ST_TAG:  s_tready = 1'b0;
                ST_DROP: s_tready = 1'b1;
                default: s_tready = out_free;
            endcase
        end
        accept = s_tvalid && s_tready;

        case (state)
            ST_FIRST: begin
                if (accept) begin
                    if ((s_vlan != port_vlan) && !port_trunk) begin
                        if (s_tlast) inc_dropped = 1'b1;
                        else         state_nxt   = ST_DROP;
                    end else begin
                        load     = 1'b1;
                        tag_nxt  = (s_vlan != port_vlan);
                        vlan_nxt = s_vlan;
                        hdr2_nxt = 1'b0;
                        if (s_tlast) begin
                            ld_user  = 1'b1;
                            inc_runt = 1'b1;
                        end else begin
                            state_nxt = ST_HDR;
                        end
                    end
                end
            end
            ST_HDR: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_tlast) begin
                        // runts never get a tag, even when the decision said so
                        ld_user   = 1'b1;
                        inc_runt  = 1'b1;
                        state_nxt = ST_FIRST;
                    end else if (hdr2_q) begin
                        state_nxt = tag_q ? ST_TAG : ST_BODY;
                    end else begin
                        hdr2_nxt = 1'b1;
                    end
                end
            end
            ST_TAG: begin
                if (out_free) begin
                    load       = 1'b1;
                    ld_data    = {vlan_q[7:0], 4'h0, vlan_q[11:8], TPID[7:0], TPID[15:8]};
                    ld_keep    = 4'hf;
                    ld_last    = 1'b0;
                    ld_user    = 1'b0;
                    inc_tagged = 1'b1;
                    state_nxt  = ST_BODY;
                end
            end
            ST_BODY: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_tlast) state_nxt = ST_FIRST;
                end
            end
            ST_DROP: begin
                if (accept && s_tlast) begin
                    inc_dropped = 1'b1;
                    state_nxt   = ST_FIRST;
                end
            end
            default: state_nxt = ST_FIRST;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state  <= ST_FIRST;
            tag_q  <= 1'b0;
            hdr2_q <= 1'b0;
            vlan_q <= 12'h000;
        end else begin
            state  <= state_nxt;
            tag_q  <= tag_nxt;
            hdr2_q <= hdr2_nxt;
            vlan_q <= vlan_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= 32'h0;
            m_tkeep  <= 4'h0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= ld_data;
            m_tkeep  <= ld_keep;
            m_tlast  <= ld_last;
            m_tuser  <= ld_user;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            cnt_tagged  <= '0;
            cnt_dropped <= '0;
            cnt_runt    <= '0;
        end else begin
            if (inc_tagged)  cnt_tagged  <= cnt_tagged + CNT_ONE;
            if (inc_dropped) cnt_dropped <= cnt_dropped + CNT_ONE;
            if (inc_runt)    cnt_runt    <= cnt_runt + CNT_ONE;
        end
    end

endmodule
